// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared definitions for the ROM fetch sequencer.
// Contents:
//   state_t         - sequencer FSM encoding (IDLE, CHECK, FETCH, DRAIN)
//   ROM_RD_LATENCY  - cycles from address presentation to ROM data
//   BUF_DEPTH       - entries in the output skid buffer
package rom_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int ROM_RD_LATENCY = 1;
  localparam int BUF_DEPTH      = 2;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO that buffers ROM words between the ROM and the consumer.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push         - write push_data this cycle
//   push_data    - word to store
//   pop          - drop the head entry this cycle (only while head_valid)
//   head_data    - head entry, zero while empty
//   head_valid   - FIFO holds at least one entry
//   count        - occupancy (0..2), used by the fetch credit logic
module fetch_skid_fifo #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Push and pop may happen together; occupancy then stays unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  // Empty buffer presents zero so no stale word is ever visible.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Strided fetch sequencer in front of the banked coefficient ROM.
// A start command walks base, base+stride, ... for num_words steps, reads one
// NUM_BANKS-byte word per step and streams the words out on a valid/ready
// interface through a 2-entry skid buffer. Commands whose footprint would run
// past the end of the ROM are rejected with an err pulse.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   start, base_addr, stride,
//   num_words                    - command (sampled only in IDLE)
//   busy, done, err              - command status (done/err are 1-cycle pulses)
//   rom_addr, rom_dout           - ROM read port (data one cycle after address)
//   out_data, out_valid, out_ready - word stream toward the array feeder
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int ADDR_LINE  = 432,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 16,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH-1:0]            stride,
  input  logic [CNT_WIDTH-1:0]             num_words,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [DATA_WIDTH*NUM_BANKS-1:0]  rom_dout,
  output logic [DATA_WIDTH*NUM_BANKS-1:0]  out_data,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int WORD_W = DATA_WIDTH * NUM_BANKS;
  localparam int LAST_W = ADDR_WIDTH + CNT_WIDTH + 1;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [ADDR_WIDTH-1:0]     stride_q;
  logic [CNT_WIDTH-1:0]      nw_q;
  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [CNT_WIDTH-1:0]      issued;
  logic [ADDR_WIDTH-1:0]     rom_addr_q;
  logic [ROM_RD_LATENCY-1:0] rd_pipe;

  logic [1:0]                fifo_count;
  logic [1:0]                occ_after_pop;
  logic [2:0]                credit_used;
  logic                      pop;
  logic                      issue;
  logic                      last_issue;
  logic                      drain_done;
  logic [LAST_W-1:0]         last_byte;
  logic                      range_ok;

  assign pop = out_valid & out_ready;

  // Credit counts the slot freed by a pop in the same cycle, which is what
  // allows one word per cycle with out_ready held high.
  assign occ_after_pop = fifo_count - {1'b0, pop};
  assign credit_used   = {1'b0, occ_after_pop} + 3'($countones(rd_pipe));
  assign issue         = (state == ST_FETCH) && (credit_used < 3'(BUF_DEPTH));

  // The address reaches the ROM in the issue cycle so data lands in the
  // buffer one cycle later; otherwise the last issued address is held.
  assign rom_addr = issue ? cur_addr : rom_addr_q;

  // Wide enough that the end-of-footprint address can never wrap.
  assign last_byte = LAST_W'(base_q)
                   + LAST_W'(nw_q - CNT_WIDTH'(1)) * LAST_W'(stride_q)
                   + LAST_W'(NUM_BANKS);
  assign range_ok  = (last_byte <= LAST_W'(ADDR_LINE));

  assign last_issue = (issued == nw_q - CNT_WIDTH'(1));
  assign drain_done = (rd_pipe == '0) &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  fetch_skid_fifo #(
    .WIDTH(WORD_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pipe[ROM_RD_LATENCY-1]),
    .push_data (rom_dout),
    .pop       (pop),
    .head_data (out_data),
    .head_valid(out_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      stride_q   <= '0;
      nw_q       <= '0;
      cur_addr   <= '0;
      issued     <= '0;
      rom_addr_q <= '0;
      rd_pipe    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      rd_pipe <= (rd_pipe << 1) | ROM_RD_LATENCY'(issue);

      if (issue) begin
        rom_addr_q <= cur_addr;
        cur_addr   <= cur_addr + stride_q;
        issued     <= issued + CNT_WIDTH'(1);
      end

      case (state)
        ST_IDLE: begin
          // A start arriving in the done cycle is ignored.
          if (start && !done) begin
            base_q   <= base_addr;
            stride_q <= stride;
            nw_q     <= num_words;
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!range_ok) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cur_addr <= base_q;
            issued   <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue && last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: a behavioural ROM, a scoreboard of
// expected words filled at command time and a monitor that compares every
// word the DUT hands over.
module tb_rom_fetch_ctrl;

  localparam int AW = 9;
  localparam int CW = 6;
  localparam int WW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] num_words = '0;
  logic          busy, done, err;
  logic [AW-1:0] rom_addr;
  logic [WW-1:0] rom_dout;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, valid_cnt = 0, pops = 0;
  int pop_first = -1, pop_last = -1;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic [WW-1:0] exp_q[$];

  rom_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .stride(stride), .num_words(num_words), .busy(busy), .done(done),
    .err(err), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input int a);
    return 8'((a * 37 + 11) ^ (a >> 3));
  endfunction

  function automatic logic [WW-1:0] exp_word(input int a);
    logic [WW-1:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = rom_byte(a + k);
    return w;
  endfunction

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk)
    for (int k = 0; k < 16; k++) rom_dout[k*8 +: 8] <= rom_byte(int'(rom_addr) + k);

  task automatic checkOutput(input string name, input logic [WW-1:0] act,
                             input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Consumer: ready pattern per mode (0: always, 1: 1,0,0,1 repeating).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready_mode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else                 out_ready = 1'b1;
    end
  end

  // Monitor: pop the scoreboard on every handshake, check stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (prev_stall) begin
        checkOutput("stall_valid", WW'(out_valid), WW'(1));
        checkOutput("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got %h expected none", out_data);
        end else begin
          checkOutput("word", out_data, exp_q.pop_front());
        end
        pops++;
        if (pop_first < 0) pop_first = cyc;
        pop_last = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic applyStimulus(input int b, input int s, input int n, input bit push_exp);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = AW'(b); stride = AW'(s); num_words = CW'(n);
    if (push_exp)
      for (int k = 0; k < n; k++) exp_q.push_back(exp_word(b + k * s));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitEnd(input int ev0, input string name);
    int n = 0;
    while ((done_cnt + err_cnt) <= ev0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no done/err expected one within 400 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0, e0, b0, v0;

    // Reset state
    #2;
    checkOutput("rst_busy", WW'(busy), '0);
    checkOutput("rst_done", WW'(done), '0);
    checkOutput("rst_err", WW'(err), '0);
    checkOutput("rst_valid", WW'(out_valid), '0);
    checkOutput("rst_addr", WW'(rom_addr), '0);
    checkOutput("rst_data", out_data, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: streaming with ready high, four words on consecutive cycles
    $display("[TB] basic stream");
    d0 = done_cnt; e0 = err_cnt; pop_first = -1;
    applyStimulus(0, 16, 4, 1'b1);
    waitEnd(d0 + e0, "t1");
    checkOutput("t1_done", WW'(done_cnt - d0), WW'(1));
    checkOutput("t1_busy", WW'(busy), '0);
    checkOutput("t1_left", WW'(exp_q.size()), '0);
    checkOutput("t1_consec", WW'(pop_last - pop_first), WW'(3));
    repeat (5) @(negedge clk);
    checkOutput("t1_done_once", WW'(done_cnt - d0), WW'(1));

    // 2: backpressure pattern
    $display("[TB] backpressure");
    ready_mode = 1;
    d0 = done_cnt; e0 = err_cnt; v0 = pops;
    applyStimulus(0, 16, 4, 1'b1);
    waitEnd(d0 + e0, "t2");
    checkOutput("t2_done", WW'(done_cnt - d0), WW'(1));
    checkOutput("t2_pops", WW'(pops - v0), WW'(4));
    checkOutput("t2_left", WW'(exp_q.size()), '0);
    ready_mode = 0;

    // 3: footprint boundary, accepted at exactly 432 then rejected at 433
    $display("[TB] boundary");
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(416, 16, 1, 1'b1);
    waitEnd(d0 + e0, "t3a");
    checkOutput("t3a_done", WW'(done_cnt - d0), WW'(1));
    checkOutput("t3a_err", WW'(err_cnt - e0), '0);
    checkOutput("t3a_left", WW'(exp_q.size()), '0);
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    applyStimulus(417, 16, 1, 1'b0);
    waitEnd(d0 + e0, "t3b");
    checkOutput("t3b_err", WW'(err_cnt - e0), WW'(1));
    checkOutput("t3b_done", WW'(done_cnt - d0), '0);
    checkOutput("t3b_busy_cycles", WW'(busy_cnt - b0), WW'(1));
    checkOutput("t3b_addr_held", WW'(rom_addr), WW'(416));

    // 4: zero-length command, then a start while busy
    $display("[TB] no-op and ignored start");
    d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt; b0 = busy_cnt;
    applyStimulus(0, 16, 0, 1'b0);
    waitEnd(d0 + e0, "t4a");
    checkOutput("t4a_done", WW'(done_cnt - d0), WW'(1));
    checkOutput("t4a_valid", WW'(valid_cnt - v0), '0);
    checkOutput("t4a_busy", WW'(busy_cnt - b0), '0);
    ready_mode = 1;
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(64, 32, 4, 1'b1);
    repeat (2) @(posedge clk);
    applyStimulus(256, 16, 4, 1'b0);
    waitEnd(d0 + e0, "t4b");
    repeat (20) @(negedge clk);
    checkOutput("t4b_done", WW'(done_cnt - d0), WW'(1));
    checkOutput("t4b_left", WW'(exp_q.size()), '0);
    ready_mode = 0;

    // 5: asynchronous reset mid-command, then a fresh command
    $display("[TB] reset mid-fetch");
    v0 = pops;
    applyStimulus(0, 16, 4, 1'b1);
    begin
      int n = 0;
      while (pops < v0 + 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        total++;
        bad++;
        $display("[TB] FAIL t5_pop_timeout: got %0d pops expected 2", pops - v0);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", WW'(out_valid), '0);
    checkOutput("t5_rst_data", out_data, '0);
    checkOutput("t5_rst_busy", WW'(busy), '0);
    checkOutput("t5_rst_addr", WW'(rom_addr), '0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (4) @(negedge clk);
    checkOutput("t5_no_stale", WW'(valid_cnt - v0), '0);
    checkOutput("t5_idle", WW'(busy), '0);
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(32, 48, 3, 1'b1);
    waitEnd(d0 + e0, "t5");
    checkOutput("t5_done", WW'(done_cnt - d0), WW'(1));
    checkOutput("t5_left", WW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
- Sequencer in front of the 16-bank synchronous coefficient ROM (1-cycle read latency, NUM_BANKS consecutive bytes per read).
- On a start command it walks a strided address sequence, reads one NUM_BANKS-byte word per step, and presents each word on a valid/ready stream toward the systolic array feeder.
- Absorbs ROM latency and downstream backpressure with a 2-entry output buffer. Rejects commands whose footprint exceeds the ROM.

Parameters:
ADDR_WIDTH, 9, ROM address width
ADDR_LINE, 432, ROM depth in bytes
DATA_WIDTH, 8, bits per ROM byte
NUM_BANKS, 16, bytes returned per ROM read
CNT_WIDTH, 6, width of word-count field (max 63 words per command)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_WIDTH  first byte address
stride  in  ADDR_WIDTH  byte increment between words
num_words  in  CNT_WIDTH  words to fetch; 0 = no-op
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, command complete
err  out  1  one-cycle pulse, command rejected
rom_addr  out  ADDR_WIDTH  address to ROM
rom_dout  in  DATA_WIDTH*NUM_BANKS  ROM read data (one cycle after rom_addr)
out_data  out  DATA_WIDTH*NUM_BANKS  word to consumer
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when valid&ready

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, err, out_valid = 0; rom_addr = 0; out_data = 0; counters and buffer cleared. Any in-flight command is abandoned and no stale word is emitted after reset release.
- FSM states: IDLE, CHECK, FETCH, DRAIN.
- IDLE: start=1 latches base_addr, stride, num_words -> CHECK. num_words=0 -> done pulse next cycle, no ROM reads, back to IDLE. start is ignored in all other states.
- CHECK (1 cycle): compute last = base + (num_words-1)*stride + NUM_BANKS in ADDR_WIDTH+CNT_WIDTH+1 bits, no truncation. If last > ADDR_LINE: err pulse, -> IDLE, busy drops in the same cycle. Otherwise -> FETCH. busy=1 in CHECK.
- FETCH: issue one read per cycle when credit allows. Credit rule: buffered_count + inflight < 2, where inflight is 1 for the cycle after an issue. On issue, rom_addr = current address, address += stride, issued_count += 1. After the last issue -> DRAIN.
- ROM data is captured into the buffer the cycle after issue. Buffer is a 2-entry FIFO; out_data/out_valid reflect the head entry.
- Order is preserved. Word k carries rom bytes [addr_k .. addr_k+NUM_BANKS-1], with byte 0 in bits [DATA_WIDTH-1:0].
- Throughput: with out_ready held high, 1 word/cycle. The first out_valid occurs 2 cycles after the FETCH entry cycle.
- Simultaneous capture and pop in the same cycle is legal; occupancy stays unchanged.
- DRAIN: wait until all words have popped. Then done pulses 1 cycle, busy drops with done, -> IDLE. A start in the done cycle is ignored.
- rom_addr holds its last value when no read is issued.
- Address arithmetic is never allowed to wrap; the CHECK state guarantees this.

Decomposition:
- Shared package: FSM state encoding and a constant for the ROM read latency (1).
- One sub-module, fetch_skid_fifo: the 2-entry FIFO with occupancy count. It exposes occupancy to the credit logic and implements push/pop with simultaneous push+pop.

Test Plan:
1. base=0, stride=16, num_words=4, out_ready=1 -> rom_addr 0,16,32,48 on consecutive cycles. out_data = bytes 0-15, 16-31, 32-47, 48-63 on 4 consecutive cycles. done once, busy low afterwards.
2. Same command, out_ready toggles 1,0,0,1,... -> no word lost or duplicated. No more than 2 reads outstanding or buffered. out_data stays stable while valid and not ready.
3. base=416, stride=16, num_words=1 -> accepted (last=432). base=417, num_words=1 -> err pulse, no ROM address change, busy high for exactly 1 cycle (CHECK).
4. num_words=0 -> done pulse, out_valid never asserts. Also: start asserted while busy -> ignored, and the current sequence completes unchanged.
5. rst_n driven low mid-FETCH after 2 words are delivered -> outputs zero immediately (async). After release the block is IDLE, and a new command base=32, stride=48, num_words=3 yields addresses 32, 80, 128 correctly.
